seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
Parametrised time-multiplexed driver for common-cathode 7-segment displays with N digit grounds (digits plus colon).
- Scans slots in a fixed order from a built-in prescaler.
- Decodes a 4-bit code per slot to segments.
- Applies per-slot blanking, an anti-ghost guard interval and 8-level brightness PWM.
- Sits between the clock/time-keeping logic and the display pins.
- Generalises the fixed 5-slot, always-full-brightness scanner to any slot count and scan rate.

Parameters:
- NUM_DIGITS, 5, number of scanned slots (digit grounds); slot 0 = rightmost (minutes ones), must be >= 2.
- CLK_DIV, 8000, Clock cycles per slot; must be >= 16.
- GUARD, 4, cycles at the start of each slot with all grounds off; must be < CLK_DIV/2.

Ports:
- Clock  in  1  system clock (10 MHz on board).
- Reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = scan; 0 = freeze counters and drive display dark.
- digits  in  4*NUM_DIGITS  per-slot code; slot i = digits[4i+3:4i].
- blank  in  NUM_DIGITS  1 = slot i dark (e.g. colon off, leading zero).
- brightness  in  3  0 = 1/8 duty .. 7 = full duty.
- DisplayGround  out  NUM_DIGITS  active-low digit select; at most one bit low.
- inputDisplay  out  7  segments, bit0 = A .. bit6 = G, 1 = lit.
- slot_idx  out  clog2(NUM_DIGITS)  slot currently being scanned.
- frame_tick  out  1  one-cycle pulse when slot wraps from NUM_DIGITS-1 to 0.

Behaviour:
- Reset (synchronous, active-high), effective the next edge:
  - cnt = 0, slot_idx = 0, frame_tick = 0.
  - DisplayGround all 1s, inputDisplay = 0.
  - Snapshot: digits = 0, blank = all 1s.
  - Reset mid-slot abandons the slot immediately; no partial pulse follows.
- Prescaler, when enable = 1:
  - cnt counts 0..CLK_DIV-1, then wraps to 0.
  - On wrap, slot_idx increments modulo NUM_DIGITS.
  - frame_tick = 1 in the cycle slot_idx becomes 0.
- Snapshot: digits and blank are captured on the wrap edge into slot 0. The whole frame uses consistent data (no tearing).
- Brightness: captured at each slot's cnt = 0.
  - on_len = ((CLK_DIV - GUARD) * (brightness + 1)) >> 3, computed at full width with no truncation before the shift.
- Lit condition: the slot is lit when all of the following hold:
  - enable = 1
  - GUARD <= cnt < GUARD + on_len
  - snapshot blank[slot_idx] = 0
- Outputs are registered with 1-cycle latency from the condition:
  - Lit: DisplayGround = ~(1 << slot_idx) and inputDisplay = decode(snapshot code).
  - Not lit: DisplayGround all 1s and inputDisplay = 0.
- Decode (bits GFEDCBA):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Codes 10-15: see Optional Feature.
- enable = 0: cnt and slot_idx hold, frame_tick = 0, outputs go dark on the next edge. Re-enable resumes from the held cnt and slot.
- Invariants:
  - At most one DisplayGround bit is low.
  - Grounds are never low when inputDisplay = 0 due to blanking.
  - Grounds are never low during guard cycles.

Optional Feature:
- Macro SEG7_HEX_DECODE_EN.
- Defined: codes 10-15 decode to A = 1110111, b = 1111100, C = 0111001, d = 1011110, E = 1111001, F = 1110001.
- Undefined: codes 10-15 decode to 0000000, and the slot stays dark even though its ground is low. This gives error visibility by absence.

Decomposition:
- Package seg7_pkg:
  - segment-pattern localparams SEG_0..SEG_F and SEG_OFF;
  - ground-polarity constant GND_OFF = 1'b1;
  - brightness width constant BRIGHT_W = 3.
- Sub-module seg7_decode: purely combinational, 4-bit code in, 7-bit segments out. It holds the SEG7_HEX_DECODE_EN conditional.
- The scan/PWM/snapshot logic stays in seg7_scan_mux.

Test Plan:
1. Full brightness scan. NUM_DIGITS = 5, CLK_DIV = 16, GUARD = 2; digits = 0x12345, blank = 0, brightness = 7, release reset.
   - During slot 0, DisplayGround = 11110 and inputDisplay = 1101101 ("5") for cnt 3..16 (registered, on_len = 14).
   - Slot 1 uses 11101 and "4", and so on.
   - frame_tick pulses every 80 cycles.
2. Minimum brightness. Same setup with brightness = 0.
   - on_len = 1: each slot is lit exactly 1 cycle, right after the guard.
   - No overlap of low grounds across slots.
3. Blanking and tear-free update.
   - blank = 00100 → slot 2 grounds never go low.
   - Change digits mid-frame to 0x99999 → the new values appear only after the next frame_tick.
4. Enable and reset mid-slot.
   - enable = 0 at cnt = 7 of slot 3 → outputs dark next cycle, slot_idx holds 3, resumes at cnt 7.
   - Reset at slot 2 → all grounds 1s next cycle, slot_idx = 0.
5. Hex decode. digits slot 0 = 4'hA.
   - With SEG7_HEX_DECODE_EN: inputDisplay = 1110111.
   - Without: inputDisplay = 0000000 while the ground is low.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns
// (bit order GFEDCBA, 1 = lit), ground polarity and brightness width.
package seg7_pkg;

  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b1111100;
  localparam logic [6:0] SEG_C   = 7'b0111001;
  localparam logic [6:0] SEG_D   = 7'b1011110;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_F   = 7'b1110001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Grounds are active-low: a released ground is driven high.
  localparam logic GND_OFF = 1'b1;

  localparam int BRIGHT_W = 3;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to 7-segment pattern decoder.
// Build option SEG7_HEX_DECODE_EN: when defined, codes 10-15 show A b C d E F;
// otherwise they decode to all segments off so a bad code is visibly blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Table lookup; unlisted codes fall through to dark.
  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
`ifdef SEG7_HEX_DECODE_EN
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
`endif
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-cathode 7-segment driver: prescaled slot scan,
// frame-wide input snapshot, guard interval and 8-level brightness PWM.
// Hex glyphs for codes 10-15 are enabled by SEG7_HEX_DECODE_EN (see seg7_decode).
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS = 5,
  parameter  int CLK_DIV    = 8000,
  parameter  int GUARD      = 4,
  localparam int SLOT_W     = $clog2(NUM_DIGITS),
  localparam int CNT_W      = $clog2(CLK_DIV)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   DisplayGround,
  output logic [6:0]              inputDisplay,
  output logic [SLOT_W-1:0]       slot_idx,
  output logic                    frame_tick
);

  localparam logic [NUM_DIGITS-1:0] GND_ALL_OFF = {NUM_DIGITS{GND_OFF}};
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    tick_q, tick_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [BRIGHT_W-1:0]     bright_q, bright_d;
  logic [NUM_DIGITS-1:0]   gnd_q, gnd_d;
  logic [6:0]              seg_q, seg_d;

  logic                    cnt_last, slot_last, lit;
  logic [31:0]             on_len, cnt_ext;
  logic [3:0]              code;
  logic [6:0]              seg_dec;

  seg7_decode u_decode (
    .code (code),
    .seg  (seg_dec)
  );

  // Next-state: prescaler, slot advance, snapshots and the registered pin image.
  always_comb begin
    cnt_last  = (cnt_q == CNT_W'(CLK_DIV - 1));
    slot_last = (slot_q == SLOT_W'(NUM_DIGITS - 1));

    // At cnt 0 the live brightness input is the value being captured, so it
    // already governs this slot even when the guard is zero cycles long.
    bright_d = (cnt_q == '0) ? brightness : bright_q;
    on_len   = (32'(CLK_DIV - GUARD) * (32'(bright_d) + 32'd1)) >> 3;
    cnt_ext  = 32'(cnt_q);

    code = snap_digits_q[{slot_q, 2'b00} +: 4];
    lit  = enable
         && (cnt_ext >= 32'(GUARD))
         && (cnt_ext < (32'(GUARD) + on_len))
         && !snap_blank_q[slot_q];

    gnd_d = lit ? ~(ONE_HOT0 << slot_q) : GND_ALL_OFF;
    seg_d = lit ? seg_dec : SEG_OFF;

    cnt_d         = cnt_q;
    slot_d        = slot_q;
    tick_d        = 1'b0;
    snap_digits_d = snap_digits_q;
    snap_blank_d  = snap_blank_q;
    if (enable) begin
      if (cnt_last) begin
        cnt_d = '0;
        if (slot_last) begin
          // Entering slot 0: latch a whole frame's worth of data at once.
          slot_d        = '0;
          tick_d        = 1'b1;
          snap_digits_d = digits;
          snap_blank_d  = blank;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset; reset drops any slot in progress.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q         <= '0;
      slot_q        <= '0;
      tick_q        <= 1'b0;
      snap_digits_q <= '0;
      snap_blank_q  <= '1;
      bright_q      <= '0;
      gnd_q         <= GND_ALL_OFF;
      seg_q         <= SEG_OFF;
    end else begin
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      tick_q        <= tick_d;
      snap_digits_q <= snap_digits_d;
      snap_blank_q  <= snap_blank_d;
      bright_q      <= bright_d;
      gnd_q         <= gnd_d;
      seg_q         <= seg_d;
    end
  end

  assign DisplayGround = gnd_q;
  assign inputDisplay  = seg_q;
  assign slot_idx      = slot_q;
  assign frame_tick    = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux (5 slots, 16 cycles per slot, guard 2).
// Each driven cycle pushes the expected pin image into exp_q; a negedge
// monitor pops and compares. Directed checks count patterns per frame.
module tb_seg7_scan_mux;

  localparam int N   = 5;
  localparam int DIV = 16;
  localparam int GRD = 2;
  localparam int W   = 16;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         enable;
  logic [19:0]  digits;
  logic [4:0]   blank;
  logic [2:0]   brightness;
  logic [4:0]   DisplayGround;
  logic [6:0]   inputDisplay;
  logic [2:0]   slot_idx;
  logic         frame_tick;

  logic [W-1:0] exp_q[$];
  int           tests = 0;
  int           fails = 0;

  // Reference state
  int           m_cnt, m_slot;
  logic [19:0]  m_dig;
  logic [4:0]   m_blk;
  logic [2:0]   m_br;

  seg7_scan_mux #(.NUM_DIGITS(N), .CLK_DIV(DIV), .GUARD(GRD)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .enable        (enable),
    .digits        (digits),
    .blank         (blank),
    .brightness    (brightness),
    .DisplayGround (DisplayGround),
    .inputDisplay  (inputDisplay),
    .slot_idx      (slot_idx),
    .frame_tick    (frame_tick)
  );

  // Clock / reset
  always #5 Clock = ~Clock;

  function automatic logic [6:0] ref_seg(input logic [3:0] c);
    case (c)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
`ifdef SEG7_HEX_DECODE_EN
      4'd10: return 7'b1110111;
      4'd11: return 7'b1111100;
      4'd12: return 7'b0111001;
      4'd13: return 7'b1011110;
      4'd14: return 7'b1111001;
      4'd15: return 7'b1110001;
`endif
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: one clock; the reference predicts the pins after this edge.
  task automatic step();
    logic [4:0] g;
    logic [6:0] s;
    logic       t;
    logic [2:0] be;
    logic       lit;
    int         onl;
    @(posedge Clock);
    if (Reset) begin
      m_cnt = 0; m_slot = 0; m_dig = '0; m_blk = '1; m_br = '0;
      g = 5'b11111; s = 7'b0; t = 1'b0;
    end else begin
      be  = (m_cnt == 0) ? brightness : m_br;
      onl = ((DIV - GRD) * (int'(be) + 1)) / 8;
      lit = enable && (m_cnt >= GRD) && (m_cnt < GRD + onl) && !m_blk[m_slot];
      g   = lit ? ~(5'b00001 << m_slot) : 5'b11111;
      s   = lit ? ref_seg(m_dig[m_slot*4 +: 4]) : 7'b0;
      if (m_cnt == 0) m_br = brightness;
      t = 1'b0;
      if (enable) begin
        if (m_cnt == DIV - 1) begin
          m_cnt = 0;
          if (m_slot == N - 1) begin
            m_slot = 0; t = 1'b1; m_dig = digits; m_blk = blank;
          end else begin
            m_slot++;
          end
        end else begin
          m_cnt++;
        end
      end
    end
    exp_q.push_back({g, s, 3'(m_slot), t});
    @(negedge Clock);
  endtask

  // Steps n cycles, counting ground matches, full matches, any-low cycles, ticks.
  task automatic run(input int n, input logic [4:0] tg, input logic [6:0] ts,
                     output int mg, output int m, output int low, output int ticks);
    mg = 0; m = 0; low = 0; ticks = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (DisplayGround == tg) mg++;
      if (DisplayGround == tg && inputDisplay == ts) m++;
      if (DisplayGround != 5'b11111) low++;
      if (frame_tick) ticks++;
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({DisplayGround, inputDisplay, slot_idx, frame_tick} !== e) begin
        fails++;
        if (fails < 30)
          $display("FAIL scan_cycle @%0t: gnd=%b seg=%b slot=%0d tick=%b expected gnd=%b seg=%b slot=%0d tick=%b",
                   $time, DisplayGround, inputDisplay, slot_idx, frame_tick,
                   e[15:11], e[10:4], e[3:1], e[0]);
      end
    end
  end

  initial begin
    int mg, m, l, t, mg2, m2, l2, t2;
    logic [6:0] hex_a;
    Reset = 1'b1; enable = 1'b1; digits = 20'h12345; blank = 5'b0; brightness = 3'd7;
    repeat (3) step();
    check("reset_gnd", DisplayGround, 5'b11111);
    check("reset_seg", inputDisplay, 0);
    check("reset_slot", slot_idx, 0);
    check("reset_tick", frame_tick, 0);
    Reset = 1'b0;

    // Full brightness: first frame shows the reset snapshot (all blank).
    run(80, 5'b11110, 7'b1101101, mg, m, l, t);
    check("frame1_dark", l, 0);
    check("frame1_ticks", t, 1);
    run(160, 5'b11110, 7'b1101101, mg, m, l, t);
    check("full_slot0_five", m, 28);
    check("full_ticks", t, 2);
    check("full_low_total", l, 140);

    // Minimum brightness: one lit cycle per slot.
    brightness = 3'd0;
    run(80, 5'b11110, 7'b1101101, mg, m, l, t);
    check("min_slot0_five", m, 1);
    check("min_low_total", l, 5);

    // Blank slot 2 takes effect one frame later (snapshot already taken).
    brightness = 3'd7; blank = 5'b00100;
    run(80, 5'b11011, 7'b1001111, mg, m, l, t);
    check("preblank_slot2_three", m, 14);
    run(30, 5'b11011, 7'b1101111, mg, m, l, t);
    digits = 20'h99999;
    run(50, 5'b10111, 7'b1101111, mg2, m2, l2, t2);
    check("blank_slot2_never_low", mg, 0);
    check("no_tear_slot3_nine", m2, 0);
    check("no_tear_slot3_lit", mg2, 14);
    check("blank_frame_low", l + l2, 56);
    run(80, 5'b10111, 7'b1101111, mg, m, l, t);
    check("new_digits_slot3_nine", m, 14);
    check("new_digits_low", l, 56);

    // Enable dropped at slot 3 cnt 7.
    run(55, 5'b11111, 7'b0, mg, m, l, t);
    enable = 1'b0;
    step();
    check("disable_gnd", DisplayGround, 5'b11111);
    check("disable_seg", inputDisplay, 0);
    check("disable_slot", slot_idx, 3);
    run(5, 5'b11111, 7'b0, mg, m, l, t);
    check("disable_hold_low", l, 0);
    check("disable_hold_slot", slot_idx, 3);
    enable = 1'b1;
    step();
    check("resume_gnd", DisplayGround, 5'b10111);
    check("resume_seg", inputDisplay, 7'b1101111);

    // Reset in the middle of slot 2.
    run(61, 5'b11111, 7'b0, mg, m, l, t);
    check("pre_reset_slot", slot_idx, 2);
    Reset = 1'b1;
    step();
    check("midreset_gnd", DisplayGround, 5'b11111);
    check("midreset_seg", inputDisplay, 0);
    check("midreset_slot", slot_idx, 0);
    Reset = 1'b0; digits = 20'h9999A; blank = 5'b0;
    run(80, 5'b11110, 7'b0, mg, m, l, t);
    check("post_reset_dark", l, 0);

    // Hex code on slot 0.
`ifdef SEG7_HEX_DECODE_EN
    hex_a = 7'b1110111;
`else
    hex_a = 7'b0000000;
`endif
    run(80, 5'b11110, hex_a, mg, m, l, t);
    check("hex_slot0_ground", mg, 14);
    check("hex_slot0_seg", m, 14);

    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
